// File: rtl/bus_port_fifo.sv
// Bus port: first-word-fall-through TX FIFO toward the bus plus a one-deep RX capture register.
// Optional per-port traffic counters are built only when PORT_STATS_EN is defined.
module bus_port_fifo #(
    parameter int          drvrs   = 4,
    parameter int          pckg_sz = 16,
    parameter int          depth   = 8,
    parameter int          id      = 0,
    parameter logic [7:0]  bdcst   = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [pckg_sz-1:0]         wr_data,
    output logic                       full,
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    output logic                       rx_valid,
    output logic [pckg_sz-1:0]         rx_data,
    output logic                       rx_err,
    output logic [$clog2(depth):0]     count,
    output logic                       ovf,
    output logic                       udf,
    output logic [15:0]                tx_cnt,
    output logic [15:0]                rx_cnt
);

    localparam int             AW      = $clog2(depth);
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(depth);
    // Legal ids are below drvrs, so the modulo only matters for a misconfigured instance.
    localparam logic [7:0]     ID_ADDR = 8'(id % drvrs);

    logic [pckg_sz-1:0] mem_q [depth];
    logic [pckg_sz-1:0] mem_d [depth];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_err_q, rx_err_d;
    logic [pckg_sz-1:0] rx_data_q, rx_data_d;

    logic               is_full;
    logic               is_pndng;
    logic               wr_acc;
    logic               pop_acc;
    logic [7:0]         rx_addr;

    assign is_full  = (count_q == DEPTH_C);
    assign is_pndng = (count_q != '0);
    // A pop frees the head slot in the same cycle, so a write to a full FIFO is accepted then.
    assign pop_acc  = pop && is_pndng;
    assign wr_acc   = wr_en && (!is_full || pop_acc);
    assign rx_addr  = D_push[pckg_sz-1 -: 8];

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        rx_valid_d = push;
        rx_err_d   = push && (rx_addr != ID_ADDR) && (rx_addr != bdcst);
        rx_data_d  = push ? D_push : rx_data_q;

        if (wr_acc) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_en && is_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (pop && !is_pndng) begin
            udf_d = 1'b1;
        end
    end

    // Storage is not reset; D_pop is gated by occupancy so stale entries never leak out.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            rx_data_q  <= rx_data_d;
        end
    end

`ifdef PORT_STATS_EN
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (pop_acc && (tx_cnt_q != 16'hFFFF)) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end
        if (push && (rx_cnt_q != 16'hFFFF)) begin
            rx_cnt_d = rx_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    assign tx_cnt = tx_cnt_q;
    assign rx_cnt = rx_cnt_q;
`else
    assign tx_cnt = '0;
    assign rx_cnt = '0;
`endif

    assign full     = is_full;
    assign pndng    = is_pndng;
    assign D_pop    = is_pndng ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo (id=2, depth=8, 16-bit packets); counter
// expectations follow whether PORT_STATS_EN is defined for the build.
module tb_bus_port_fifo;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_err;
    logic [3:0]  count;
    logic        ovf;
    logic        udf;
    logic [15:0] tx_cnt;
    logic [15:0] rx_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bus_port_fifo #(
        .drvrs(4), .pckg_sz(16), .depth(8), .id(2), .bdcst(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_err(rx_err), .count(count), .ovf(ovf), .udf(udf),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs; outputs are observed 1ns after the edge.
    task automatic step(input logic rs, input logic w, input logic [15:0] wd,
                        input logic p, input logic ps, input logic [15:0] dp);
        reset = rs; wr_en = w; wr_data = wd; pop = p; push = ps; D_push = dp;
        @(posedge clk);
        #1;
        reset = 1'b0; wr_en = 1'b0; pop = 1'b0; push = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h0200);
        n_cmp++; if (pndng !== 1'b0) begin n_bad++; $display("FAIL reset_pndng: got %b want 0", pndng); end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (D_pop !== 16'h0000) begin n_bad++; $display("FAIL reset_dpop: got %h want 0000", D_pop); end
        n_cmp++; if (rx_valid !== 1'b0 || rx_err !== 1'b0) begin n_bad++; $display("FAIL reset_rx: got v=%b e=%b want 0 0", rx_valid, rx_err); end
        n_cmp++; if (rx_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rxdata: got %h want 0000", rx_data); end
        n_cmp++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ovf=%b udf=%b want 0 0", ovf, udf); end
        n_cmp++; if (tx_cnt !== 16'd0 || rx_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stats: got tx=%0d rx=%0d want 0 0", tx_cnt, rx_cnt); end
    endtask

    task automatic test_basic();
        step(1'b0, 1'b1, 16'h0155, 1'b0, 1'b0, 16'h0);
        n_cmp++; if (pndng !== 1'b1 || D_pop !== 16'h0155) begin n_bad++; $display("FAIL basic_first: got pndng=%b dpop=%h want 1 0155", pndng, D_pop); end
        step(1'b0, 1'b1, 16'h0266, 1'b0, 1'b0, 16'h0);
        n_cmp++; if (count !== 4'd2 || D_pop !== 16'h0155) begin n_bad++; $display("FAIL basic_two: got count=%0d dpop=%h want 2 0155", count, D_pop); end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        n_cmp++; if (D_pop !== 16'h0266 || count !== 4'd1) begin n_bad++; $display("FAIL basic_pop1: got dpop=%h count=%0d want 0266 1", D_pop, count); end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        n_cmp++; if (pndng !== 1'b0 || count !== 4'd0 || D_pop !== 16'h0) begin n_bad++; $display("FAIL basic_empty: got pndng=%b count=%0d dpop=%h want 0 0 0000", pndng, count, D_pop); end
        n_cmp++; if (udf !== 1'b0) begin n_bad++; $display("FAIL basic_udf: got %b want 0", udf); end
    endtask

    task automatic test_full_ovf();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0);
        n_cmp++; if (full !== 1'b1 || count !== 4'd8) begin n_bad++; $display("FAIL full_set: got full=%b count=%0d want 1 8", full, count); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL full_noovf: got %b want 0", ovf); end
        step(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0);
        n_cmp++; if (ovf !== 1'b1 || count !== 4'd8) begin n_bad++; $display("FAIL ovf_set: got ovf=%b count=%0d want 1 8", ovf, count); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (D_pop !== 16'h1000 + 16'(i)) begin n_bad++; $display("FAIL full_order[%0d]: got %h want %h", i, D_pop, 16'h1000 + 16'(i)); end
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        end
        n_cmp++; if (pndng !== 1'b0 || ovf !== 1'b1) begin n_bad++; $display("FAIL full_drain: got pndng=%b ovf=%b want 0 1", pndng, ovf); end
    endtask

    task automatic test_wr_pop_full();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0);
        n_cmp++; if (count !== 4'd8 || full !== 1'b1 || ovf !== 1'b0) begin n_bad++; $display("FAIL wrpop_full: got count=%0d full=%b ovf=%b want 8 1 0", count, full, ovf); end
        for (int i = 1; i < 8; i++) begin
            n_cmp++; if (D_pop !== 16'h2000 + 16'(i)) begin n_bad++; $display("FAIL wrpop_order[%0d]: got %h want %h", i, D_pop, 16'h2000 + 16'(i)); end
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        end
        n_cmp++; if (D_pop !== 16'hBEEF || count !== 4'd1) begin n_bad++; $display("FAIL wrpop_last: got dpop=%h count=%0d want beef 1", D_pop, count); end
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        n_cmp++; if (pndng !== 1'b0) begin n_bad++; $display("FAIL wrpop_empty: got %b want 0", pndng); end
    endtask

    task automatic test_rx();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h02AB);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 16'h02AB || rx_err !== 1'b0) begin n_bad++; $display("FAIL rx_own: got v=%b d=%h e=%b want 1 02ab 0", rx_valid, rx_data, rx_err); end
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFF01);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 16'hFF01 || rx_err !== 1'b0) begin n_bad++; $display("FAIL rx_bcast: got v=%b d=%h e=%b want 1 ff01 0", rx_valid, rx_data, rx_err); end
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0301);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 16'h0301 || rx_err !== 1'b1) begin n_bad++; $display("FAIL rx_other: got v=%b d=%h e=%b want 1 0301 1", rx_valid, rx_data, rx_err); end
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++; if (rx_valid !== 1'b0 || rx_err !== 1'b0 || rx_data !== 16'h0301) begin n_bad++; $display("FAIL rx_idle: got v=%b d=%h e=%b want 0 0301 0", rx_valid, rx_data, rx_err); end
    endtask

    task automatic test_udf_reset();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h3001, 1'b1, 1'b0, 16'h0);
        n_cmp++; if (udf !== 1'b1 || count !== 4'd1 || D_pop !== 16'h3001) begin n_bad++; $display("FAIL udf_set: got udf=%b count=%0d dpop=%h want 1 1 3001", udf, count, D_pop); end
        step(1'b0, 1'b1, 16'h3002, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h3003, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h3004, 1'b1, 1'b0, 16'h0);
        n_cmp++; if (count !== 4'd3 || D_pop !== 16'h3002 || udf !== 1'b1) begin n_bad++; $display("FAIL udf_sticky: got count=%0d dpop=%h udf=%b want 3 3002 1", count, D_pop, udf); end
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        n_cmp++; if (pndng !== 1'b0 || udf !== 1'b0 || count !== 4'd0 || D_pop !== 16'h0) begin n_bad++; $display("FAIL udf_reset: got pndng=%b udf=%b count=%0d dpop=%h want 0 0 0 0000", pndng, udf, count, D_pop); end
    endtask

    task automatic test_stats();
        logic [15:0] exp_tx;
        logic [15:0] exp_rx;
`ifdef PORT_STATS_EN
        exp_tx = 16'd5;
        exp_rx = 16'd3;
`else
        exp_tx = 16'd0;
        exp_rx = 16'd0;
`endif
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0200 + 16'(i));
        n_cmp++; if (tx_cnt !== exp_tx) begin n_bad++; $display("FAIL stats_tx: got %0d want %0d", tx_cnt, exp_tx); end
        n_cmp++; if (rx_cnt !== exp_rx) begin n_bad++; $display("FAIL stats_rx: got %0d want %0d", rx_cnt, exp_rx); end
        n_cmp++; if (udf !== 1'b1) begin n_bad++; $display("FAIL stats_udf: got %b want 1", udf); end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; pop = 1'b0; push = 1'b0; D_push = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_full_ovf();
        test_wr_pop_full();
        test_rx();
        test_udf_reset();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
